// File: rtl/text_draw_ctrl.sv
// -----------------------------------------------------------------------------
// text_draw_ctrl
//
// Renders a string of 8x16 glyphs into a pixel write stream. The block walks a
// text ROM of 7-bit character codes, fetches each 24-bit glyph row
// (8 pixels x 3-bit palette index) from a glyph ROM, drives each palette index
// into an external combinational color transform, and emits the resulting
// RGB565 pixel with its screen coordinate over a valid/ready write port.
// Rendering order: character, then row 0..15, then pixel 0..7 left to right.
//
// Ports:
//   Clk, Reset_n        clock (rising edge), asynchronous active-low reset
//   start               draw request, sampled only while idle
//   str_base, str_len   text ROM address of first character, character count
//   origin_x, origin_y  top-left screen pixel of the first glyph
//   busy, done          busy while drawing, single-cycle completion pulse
//   txt_addr/txt_data   text ROM port (1-cycle synchronous read)
//   glyph_addr/glyph_data glyph ROM port, address {char_code, row}
//   pix_index/color_in  palette index out, RGB565 back from color transform
//   wr_valid/wr_ready   pixel write handshake
//   wr_x, wr_y, wr_color pixel coordinate (mod 1024) and color
//
// Configuration macro:
//   TEXT_TRANSPARENT_EN  when defined, pixels with palette index 0 are skipped:
//                        they take one cycle with wr_valid low and are not
//                        written. When undefined every pixel is written.
// -----------------------------------------------------------------------------
module text_draw_ctrl #(
  parameter int TXT_AW = 8,
  parameter int LEN_W  = 5
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [TXT_AW-1:0] str_base,
  input  logic [LEN_W-1:0]  str_len,
  input  logic [9:0]        origin_x,
  input  logic [9:0]        origin_y,
  output logic              busy,
  output logic              done,
  output logic [TXT_AW-1:0] txt_addr,
  input  logic [6:0]        txt_data,
  output logic [10:0]       glyph_addr,
  input  logic [23:0]       glyph_data,
  output logic [2:0]        pix_index,
  input  logic [15:0]       color_in,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [9:0]        wr_x,
  output logic [9:0]        wr_y,
  output logic [15:0]       wr_color
);

`ifdef TEXT_TRANSPARENT_EN
  localparam logic TRANSP_EN = 1'b1;
`else
  localparam logic TRANSP_EN = 1'b0;
`endif

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CLAT  = 3'd2,
    S_RREQ  = 3'd3,
    S_RLAT  = 3'd4,
    S_EMIT  = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  // A pixel is written unless transparency is enabled and its index is 0.
  function automatic logic pix_writes(input logic [2:0] idx);
    pix_writes = (!TRANSP_EN) || (idx != 3'd0);
  endfunction

  state_e              state_q, state_d;
  logic [TXT_AW-1:0]   base_q, base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [9:0]          ox_q, ox_d;
  logic [9:0]          oy_q, oy_d;
  logic [LEN_W-1:0]    char_idx_q, char_idx_d;
  logic [3:0]          row_q, row_d;
  logic [2:0]          pix_q, pix_d;
  logic [6:0]          code_q, code_d;
  logic [23:0]         shift_q, shift_d;
  logic [TXT_AW-1:0]   txt_addr_q, txt_addr_d;
  logic [10:0]         glyph_addr_q, glyph_addr_d;
  logic [9:0]          wr_x_q, wr_x_d;
  logic [9:0]          wr_y_q, wr_y_d;
  logic                wr_valid_q, wr_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                advance_s;
  logic                last_pix_s;
  logic                last_row_s;
  logic                last_char_s;
  logic [3:0]          row_inc_s;
  logic [LEN_W-1:0]    char_inc_s;

  // Pixel advance: a completed transfer, or a transparent pixel (wr_valid low
  // inside EMIT only happens when transparency is enabled).
  always_comb begin
    advance_s   = (state_q == S_EMIT) &&
                  (wr_valid_q ? wr_ready : TRANSP_EN);
    last_pix_s  = (pix_q == 3'd7);
    last_row_s  = (row_q == 4'd15);
    last_char_s = (char_idx_q == (len_q - LEN_ONE));
    row_inc_s   = row_q + 4'd1;
    char_inc_s  = char_idx_q + LEN_ONE;
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (str_len == LEN_W'(0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: state_d = S_CLAT;
      S_CLAT:  state_d = S_RREQ;
      S_RREQ:  state_d = S_RLAT;
      S_RLAT:  state_d = S_EMIT;
      S_EMIT: begin
        if (advance_s && last_pix_s) begin
          if (!last_row_s) begin
            state_d = S_RREQ;
          end else if (!last_char_s) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_EMIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values. Every output is registered, so each
  // address/coordinate is loaded on the edge that enters the state using it.
  always_comb begin
    base_d       = base_q;
    len_d        = len_q;
    ox_d         = ox_q;
    oy_d         = oy_q;
    char_idx_d   = char_idx_q;
    row_d        = row_q;
    pix_d        = pix_q;
    code_d       = code_q;
    shift_d      = shift_q;
    txt_addr_d   = txt_addr_q;
    glyph_addr_d = glyph_addr_q;
    wr_x_d       = wr_x_q;
    wr_y_d       = wr_y_q;
    wr_valid_d   = wr_valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d     = str_base;
          len_d      = str_len;
          ox_d       = origin_x;
          oy_d       = origin_y;
          char_idx_d = LEN_W'(0);
          row_d      = 4'd0;
          pix_d      = 3'd0;
          txt_addr_d = str_base;
        end else begin
          wr_valid_d = 1'b0;
        end
      end
      S_CLAT: begin
        code_d       = txt_data;
        glyph_addr_d = {txt_data, row_q};
      end
      S_RLAT: begin
        shift_d    = glyph_data;
        pix_d      = 3'd0;
        wr_x_d     = ox_q + 10'({char_idx_q, 3'b000});
        wr_y_d     = oy_q + {6'd0, row_q};
        wr_valid_d = pix_writes(glyph_data[23:21]);
      end
      S_EMIT: begin
        if (advance_s) begin
          // The final shift empties the register, so pix_index idles at 0.
          shift_d = {shift_q[20:0], 3'b000};
          if (!last_pix_s) begin
            pix_d      = pix_q + 3'd1;
            wr_x_d     = wr_x_q + 10'd1;
            wr_valid_d = pix_writes(shift_q[20:18]);
          end else begin
            pix_d      = 3'd0;
            wr_valid_d = 1'b0;
            if (!last_row_s) begin
              row_d        = row_inc_s;
              glyph_addr_d = {code_q, row_inc_s};
            end else if (!last_char_s) begin
              row_d      = 4'd0;
              char_idx_d = char_inc_s;
              txt_addr_d = base_q + TXT_AW'(char_inc_s);
            end else begin
              row_d = row_q;
            end
          end
        end else begin
          wr_valid_d = wr_valid_q;
        end
      end
      default: begin
        wr_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d == S_FETCH) || (state_d == S_CLAT) || (state_d == S_RREQ) ||
             (state_d == S_RLAT)  || (state_d == S_EMIT);
    done_d = (state_d == S_DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      base_q       <= '0;
      len_q        <= '0;
      ox_q         <= 10'd0;
      oy_q         <= 10'd0;
      char_idx_q   <= '0;
      row_q        <= 4'd0;
      pix_q        <= 3'd0;
      code_q       <= 7'd0;
      shift_q      <= 24'd0;
      txt_addr_q   <= '0;
      glyph_addr_q <= 11'd0;
      wr_x_q       <= 10'd0;
      wr_y_q       <= 10'd0;
      wr_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      base_q       <= base_d;
      len_q        <= len_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      char_idx_q   <= char_idx_d;
      row_q        <= row_d;
      pix_q        <= pix_d;
      code_q       <= code_d;
      shift_q      <= shift_d;
      txt_addr_q   <= txt_addr_d;
      glyph_addr_q <= glyph_addr_d;
      wr_x_q       <= wr_x_d;
      wr_y_q       <= wr_y_d;
      wr_valid_q   <= wr_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign txt_addr   = txt_addr_q;
  assign glyph_addr = glyph_addr_q;
  assign pix_index  = shift_q[23:21];
  assign wr_valid   = wr_valid_q;
  assign wr_x       = wr_x_q;
  assign wr_y       = wr_y_q;
  assign wr_color   = color_in;

endmodule

// File: tb/tb_text_draw_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for text_draw_ctrl. Expected pixels come from a reference model
// that walks the string with plain loops over the ROM arrays; a monitor pops
// and compares them as the DUT transfers pixels.
// -----------------------------------------------------------------------------
module tb_text_draw_ctrl;

`ifdef TEXT_TRANSPARENT_EN
  localparam bit TB_TRANSP = 1'b1;
`else
  localparam bit TB_TRANSP = 1'b0;
`endif

  logic        Clk;
  logic        Reset_n;
  logic        start;
  logic [7:0]  str_base;
  logic [4:0]  str_len;
  logic [9:0]  origin_x, origin_y;
  logic        busy, done;
  logic [7:0]  txt_addr;
  logic [6:0]  txt_data;
  logic [10:0] glyph_addr;
  logic [23:0] glyph_data;
  logic [2:0]  pix_index;
  logic [15:0] color_in;
  logic        wr_valid, wr_ready;
  logic [9:0]  wr_x, wr_y;
  logic [15:0] wr_color;

  logic [6:0]  txt_rom   [256];
  logic [23:0] glyph_rom [2048];
  logic [15:0] pal       [8];

  logic [35:0] sb[$];
  int          passed = 0;
  int          total  = 0;
  int          pops   = 0;

  text_draw_ctrl #(.TXT_AW(8), .LEN_W(5)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start),
    .str_base(str_base), .str_len(str_len),
    .origin_x(origin_x), .origin_y(origin_y),
    .busy(busy), .done(done),
    .txt_addr(txt_addr), .txt_data(txt_data),
    .glyph_addr(glyph_addr), .glyph_data(glyph_data),
    .pix_index(pix_index), .color_in(color_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Synchronous ROMs and the combinational color transform.
  always @(posedge Clk) begin
    txt_data   <= txt_rom[txt_addr];
    glyph_data <= glyph_rom[glyph_addr];
  end
  assign color_in = pal[pix_index];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: every pixel of every row of every character, in order.
  task automatic model_string(input logic [7:0] base, input int len,
                              input logic [9:0] ox, input logic [9:0] oy,
                              output int nwr);
    logic [6:0]  code;
    logic [23:0] rowbits;
    logic [2:0]  idx;
    logic [9:0]  x, y;
    nwr = 0;
    for (int c = 0; c < len; c++) begin
      code = txt_rom[8'(int'(base) + c)];
      for (int r = 0; r < 16; r++) begin
        rowbits = glyph_rom[{code, 4'(r)}];
        for (int p = 0; p < 8; p++) begin
          idx = 3'((rowbits >> (21 - 3 * p)) & 24'h7);
          if (!(TB_TRANSP && idx == 3'd0)) begin
            x = 10'(int'(ox) + 8 * c + p);
            y = 10'(int'(oy) + r);
            sb.push_back({y, x, pal[idx]});
            nwr++;
          end
        end
      end
    end
  endtask

  // Monitor: stall stability, done/valid exclusion, scoreboard compare.
  logic        stall_prev = 1'b0;
  logic [9:0]  hold_x, hold_y;
  logic [15:0] hold_c;
  logic [35:0] exp_e;
  always @(negedge Clk) begin
    if (!Reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid_held", 64'(wr_valid), 64'd1);
        check("stall_pixel_held", 64'({wr_y, wr_x, wr_color}), 64'({hold_y, hold_x, hold_c}));
      end
      if (done) check("done_without_valid", 64'(wr_valid), 64'd0);
      if (wr_valid && wr_ready) begin
        check("write_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          exp_e = sb.pop_front();
          check("pixel_yxc", 64'({wr_y, wr_x, wr_color}), 64'(exp_e));
          pops++;
        end
      end
      stall_prev = wr_valid && !wr_ready;
      hold_x = wr_x;
      hold_y = wr_y;
      hold_c = wr_color;
    end
  end

  function automatic logic ready_val(input int rmode, input int n);
    case (rmode)
      0:       ready_val = 1'b1;
      1:       ready_val = (n % 3 == 0);
      default: ready_val = 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Issue one string, scramble inputs and pulse start while busy, wait for done.
  task automatic run_string(input logic [7:0] base, input logic [4:0] len,
                            input logic [9:0] ox, input logic [9:0] oy,
                            input int rmode, input bit chk_cyc, output int nwr);
    int n;
    int p0;
    int exp_n;
    bit got;
    model_string(base, int'(len), ox, oy, exp_n);
    p0 = pops;
    str_base = base; str_len = len; origin_x = ox; origin_y = oy;
    start = 1'b1;
    wr_ready = ready_val(rmode, 0);
    n = 0; got = 1'b0;
    while (!got && n < 8000) begin
      @(posedge Clk); #1; n++;
      if (done) got = 1'b1;
      start    = (busy && !got) ? 1'($urandom_range(0, 1)) : 1'b0;
      str_base = 8'($urandom);
      str_len  = 5'($urandom);
      origin_x = 10'($urandom);
      origin_y = 10'($urandom);
      wr_ready = ready_val(rmode, n);
    end
    check("done_seen", 64'(got), 64'd1);
    if (chk_cyc) check("cycles_to_done", 64'(n), 64'(1 + int'(len) * 162));
    wr_ready = 1'b1;
    @(posedge Clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_not_busy", 64'(busy), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);
    nwr = pops - p0;
    check("write_count", 64'(nwr), 64'(exp_n));
    sb.delete();
  endtask

  initial begin
    int nwr, n, nd, nb, p0, dummy;
    Reset_n = 1'b0; start = 1'b0; wr_ready = 1'b1;
    str_base = 8'd0; str_len = 5'd0; origin_x = 10'd0; origin_y = 10'd0;
    for (int i = 0; i < 256; i++) txt_rom[i] = 7'($urandom);
    for (int i = 0; i < 2048; i++) glyph_rom[i] = 24'($urandom);
    for (int i = 0; i < 8; i++) pal[i] = 16'($urandom);
    repeat (3) @(posedge Clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(wr_valid), 64'd0);
    check("rst_addrs", 64'({txt_addr, glyph_addr}), 64'd0);
    check("rst_xy_idx", 64'({wr_x, wr_y, pix_index}), 64'd0);
    @(negedge Clk); #2 Reset_n = 1'b1;

    // Single solid glyph at (100,50).
    txt_rom[0] = 7'd5;
    for (int r = 0; r < 16; r++) glyph_rom[{7'd5, 4'(r)}] = 24'hFFFFFF;
    run_string(8'd0, 5'd1, 10'd100, 10'd50, 0, 1'b1, nwr);
    check("solid_writes", 64'(nwr), 64'd128);
    // Same glyph under 1-in-3 backpressure.
    run_string(8'd0, 5'd1, 10'd100, 10'd50, 1, 1'b0, nwr);
    check("stalled_writes", 64'(nwr), 64'd128);

    // Half-transparent rows.
    txt_rom[1] = 7'd6;
    for (int r = 0; r < 16; r++) glyph_rom[{7'd6, 4'(r)}] = 24'h000FFF;
    run_string(8'd1, 5'd1, 10'd200, 10'd300, 0, 1'b1, nwr);
    check("transp_writes", 64'(nwr), TB_TRANSP ? 64'd64 : 64'd128);

    // X wrap, text address wrap, zero length.
    run_string(8'd0, 5'd1, 10'd1020, 10'd10, 0, 1'b1, nwr);
    run_string(8'd255, 5'd2, 10'd0, 10'd1015, 0, 1'b1, nwr);
    run_string(8'd40, 5'd0, 10'd5, 10'd5, 0, 1'b1, nwr);
    check("zero_len_writes", 64'(nwr), 64'd0);

    // start held high: second string only after DONE -> IDLE.
    model_string(8'd0, 1, 10'd30, 10'd40, dummy);
    model_string(8'd0, 1, 10'd30, 10'd40, dummy);
    str_base = 8'd0; str_len = 5'd1; origin_x = 10'd30; origin_y = 10'd40;
    start = 1'b1;
    n = 0; nd = -1; nb = -1;
    while (nb < 0 && n < 2000) begin
      @(posedge Clk); #1; n++;
      if (done && nd < 0) nd = n;
      if (nd >= 0 && busy && nb < 0) nb = n;
    end
    check("held_restart_gap", 64'(nb - nd), 64'd2);
    start = 1'b0;
    n = 0; nd = -1;
    while (nd < 0 && n < 2000) begin
      @(posedge Clk); #1; n++;
      if (done) nd = n;
    end
    check("held_second_done", 64'(nd), 64'd162);
    repeat (6) @(posedge Clk);
    #1;
    check("held_no_third", 64'(busy), 64'd0);
    check("held_sb_drained", 64'(sb.size()), 64'd0);
    sb.delete();

    // Reset during row 5 of character 1 of a 3-character string.
    model_string(8'd10, 3, 10'd77, 10'd88, dummy);
    p0 = pops;
    str_base = 8'd10; str_len = 5'd3; origin_x = 10'd77; origin_y = 10'd88;
    start = 1'b1;
    n = 0;
    while ((pops - p0) < 170 && n < 3000) begin
      @(posedge Clk); #1; n++;
      start = 1'b0;
    end
    check("reached_char1_row5", 64'((pops - p0) >= 170), 64'd1);
    @(negedge Clk); #2 Reset_n = 1'b0;
    #1;
    check("arst_busy_done_valid", 64'({busy, done, wr_valid}), 64'd0);
    check("arst_addrs", 64'({txt_addr, glyph_addr}), 64'd0);
    check("arst_xy_idx", 64'({wr_x, wr_y, pix_index}), 64'd0);
    nd = 0;
    repeat (3) begin
      @(posedge Clk); #1;
      if (done) nd++;
    end
    check("arst_no_done", 64'(nd), 64'd0);
    sb.delete();
    @(negedge Clk); #2 Reset_n = 1'b1;
    run_string(8'd10, 5'd3, 10'd77, 10'd88, 0, 1'b1, nwr);

    // Random strings.
    for (int k = 0; k < 6; k++) begin
      int rm;
      rm = $urandom_range(0, 2);
      run_string(8'($urandom), 5'($urandom_range(1, 3)), 10'($urandom), 10'($urandom),
                 rm, rm == 0, nwr);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/text_draw_ctrl.md
# text_draw_ctrl

Sequencer that renders a string of glyphs into the pixel write stream. It walks a text ROM of character codes and fetches each glyph row from a glyph ROM. Each 3-bit palette index is driven into the text color transform, and each resulting RGB565 pixel is emitted with its screen coordinate over a valid/ready write port toward the frame-buffer writer.

## Interface
- TXT_AW, 8, text ROM address width
- LEN_W, 5, string length width (max 2^LEN_W−1 characters)

- Clk  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- str_base  in  TXT_AW  text ROM address of first character
- str_len  in  LEN_W  characters to draw; 0 = nothing drawn
- origin_x, origin_y  in  10 each  top-left screen pixel of first glyph
- busy  out  1  high from start acceptance until DONE
- done  out  1  single-cycle completion pulse
- txt_addr  out  TXT_AW  text ROM address (registered)
- txt_data  in  7  character code, 1-cycle synchronous read
- glyph_addr  out  11  {char_code[6:0], row[3:0]} (registered)
- glyph_data  in  24  8 pixels × 3 bits, pixel 0 = [23:21], 1-cycle read
- pix_index  out  3  current palette index to color transform
- color_in  in  16  RGB565 from color transform (combinational)
- wr_valid  out  1  pixel write valid
- wr_ready  in  1  sink accepts
- wr_x, wr_y  out  10 each  pixel coordinate
- wr_color  out  16  equals color_in

## Operation
- Glyphs are fixed at 8 wide × 16 rows. Rendering is character-major, then row 0..15, then pixel 0..7 left to right.
- States:
  - IDLE: start=1 latches the inputs, clears char_idx, row and pix. Goes to FETCH, or to DONE if str_len=0.
  - FETCH: txt_addr = str_base + char_idx (mod 2^TXT_AW). Next state is CLAT.
  - CLAT: latches txt_data into char_code. Next state is RREQ.
  - RREQ: glyph_addr = {char_code, row}. Next state is RLAT.
  - RLAT: latches glyph_data into the row shift register and sets pix=0. Next state is EMIT.
  - EMIT: presents the pixel at pix. pix advances on transfer or skip. After pix 7 it goes to:
    - RREQ, with row+1, if row<15;
    - else FETCH, with char_idx+1 and row=0, if char_idx<str_len−1;
    - else DONE.
  - DONE: done=1, busy=0. Next state is IDLE.
- pix_index = bits [23:21] of the shift register; the register shifts left by 3 per pixel advance.
- Coordinates (10-bit, wrap mod 1024, no clipping):
  - wr_x = origin_x + 8·char_idx + pix
  - wr_y = origin_y + row
- start while busy is ignored. Inputs are latched, so later changes have no effect.
- Reset values: state IDLE; busy, done and wr_valid 0; txt_addr and glyph_addr 0; wr_x and wr_y 0; pix_index 0.
- Reset_n low at any time, including mid-string, aborts immediately. No done pulse is generated. start on the first edge after release is honored.

## Timing
- Let start be sampled at edge E0. The state is FETCH after E0, CLAT after E1, RREQ after E2, RLAT after E3, and EMIT after E4. The first wr_valid is high after E4.
- Handshake: once wr_valid is high, wr_x, wr_y and pix_index (hence wr_color) are held stable until the edge where wr_valid&wr_ready. wr_valid does not drop without a transfer.
- Back-to-back pixels: one per cycle while wr_ready=1. Each new row costs 2 bubble cycles (RREQ, RLAT); each new character costs 4 (FETCH, CLAT, RREQ, RLAT).
- Minimum cycles per string (start edge to done high) = 1 + str_len·(2 + 16·(2+8)). str_len=1 gives 163.
- str_len=0: done is high after E0, and the block is in IDLE after E1.
- done is never asserted in the same cycle as wr_valid.

## Configuration
- TEXT_TRANSPARENT_EN defined: pixels with pix_index=0 are transparent. They take one EMIT cycle with wr_valid=0, are not written, and advance unconditionally.
- Undefined: every pixel, including index 0, is written (the background color is emitted).

## Test plan
- Reset mid-string: start with str_len=3; pull Reset_n low during row 5 of char 1 -> all outputs 0 asynchronously, no done; after release a new start draws correctly from char 0.
- Single glyph, wr_ready=1, macro undefined: origin (100,50), glyph rows 0xFFFFFF -> 128 writes with x 100..107 and y 50..65, all index 7; done exactly 163 cycles after the start edge.
- Backpressure: wr_ready toggling with a 1-in-3 duty -> wr_x, wr_y and wr_color stable while stalled; write count and order are identical to the unstalled run.
- Transparency, macro defined: row data 0x000FFF (pixels 0–3 index 0, pixels 4–7 index 7) -> only pixels 4–7 written per row, 64 writes total; wr_valid low on skipped cycles. The same stimulus with the macro undefined gives 128 writes.
- Wrap and zero-length:
  - origin_x=1020 with str_len=1 -> wr_x sequence 1020..1023, 0..3.
  - str_base=255 with str_len=2 -> txt_addr sequence 255, 0.
  - str_len=0 -> done after E0 with no writes.
- start held high through an entire string -> the second string begins only from IDLE after DONE; start pulses while busy have no effect.
